// File: rtl/ex_muldiv_ctrl_pkg.sv
// rtl/ex_muldiv_ctrl_pkg.sv - shared constants and types for the E-stage mul/div sequencer
package ex_muldiv_ctrl_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_CALC = CALC,
    ST_FIX  = FIX,
    ST_DONE = DONE
  } state_t;

  function automatic logic rs1_is_signed(input logic [2:0] op);
    return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] op);
    return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// rtl/ex_muldiv_ctrl_if.sv - E-stage to mul/div sequencer handshake bundle
interface ex_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs1_data_i;
  logic [WIDTH-1:0] rs2_data_i;
  logic             flush_i;
  logic             advance_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_data_i, rs2_data_i, flush_i, advance_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_data_i, rs2_data_i, flush_i, advance_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_ctrl_muldiv_core.sv
// rtl/ex_muldiv_ctrl_muldiv_core.sv - one-bit-per-cycle shift-add / restoring-divide datapath
module muldiv_core
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // acc is {product_hi, product_lo} for multiply and {remainder, quotient} for divide
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [2:0]         op_q;
  logic               neg_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   lo_fix;
  logic [WIDTH-1:0]   hi_fix;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = (div_shift >= {1'b0, opnd});
    if (op_q[2]) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      opnd  <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
    end else if (load) begin
      op_q  <= op;
      neg_q <= neg;
      if (op[2]) begin
        acc  <= {{WIDTH{1'b0}}, a};
        opnd <= b;
      end else begin
        acc  <= {{WIDTH{1'b0}}, b};
        opnd <= a;
      end
    end else if (step) begin
      acc <= acc_step;
    end
  end

  // Multiply negates the full double-width product; divide negates each half on its own
  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    lo_fix   = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    hi_fix   = neg_q ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    case (op_q)
      F3_MUL:                         result = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   result = prod_fix[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:                result = lo_fix;
      default:                        result = hi_fix;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - RV32M sequencer: FSM, pipeline stall and divide shortcuts
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             neg;
  logic             div_zero;
  logic             div_ovf;
  logic             shortcut;
  logic [WIDTH-1:0] shortcut_res;
  logic             accept;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] core_res;

  always_comb begin
    sign_a   = rs1_is_signed(bus.op_i) & bus.rs1_data_i[WIDTH-1];
    sign_b   = rs2_is_signed(bus.op_i) & bus.rs2_data_i[WIDTH-1];
    abs_a    = sign_a ? (~bus.rs1_data_i + 1'b1) : bus.rs1_data_i;
    abs_b    = sign_b ? (~bus.rs2_data_i + 1'b1) : bus.rs2_data_i;
    // Remainder takes the dividend's sign; product and quotient take the XOR
    neg      = (bus.op_i[2] & bus.op_i[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero = bus.op_i[2] & (bus.rs2_data_i == '0);
    div_ovf  = ((bus.op_i == F3_DIV) || (bus.op_i == F3_REM)) &
               (bus.rs1_data_i == MIN_NEG) & (bus.rs2_data_i == '1);
    shortcut = div_zero | div_ovf;
    if (div_zero) begin
      shortcut_res = bus.op_i[1] ? bus.rs1_data_i : '1;
    end else begin
      shortcut_res = bus.op_i[1] ? '0 : MIN_NEG;
    end
    accept = (state == ST_IDLE) & bus.start_i & ~bus.flush_i;
    load   = accept & ~shortcut;
    step   = (state == ST_CALC);
  end

  always_comb begin
    state_next = state;
    if (bus.flush_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.start_i) state_next = shortcut ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt == LAST) state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        ST_DONE: if (bus.advance_i) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
      if (accept & shortcut) begin
        result_q <= shortcut_res;
      end else if ((state == ST_FIX) & ~bus.flush_i) begin
        result_q <= core_res;
      end
    end
  end

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .op     (bus.op_i),
    .neg    (neg),
    .a      (abs_a),
    .b      (abs_b),
    .result (core_res)
  );

  assign bus.stall_o  = accept | (state == ST_CALC) | (state == ST_FIX);
  assign bus.done_o   = (state == ST_DONE);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb/tb_ex_muldiv_ctrl.sv - directed self-checking bench for ex_muldiv_ctrl
module tb_ex_muldiv_ctrl;
  import ex_muldiv_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a falling edge; that cycle is cycle 0 of the op
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int dcyc, output int scyc,
                        output logic [31:0] res, output logic stall_at_done);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    dcyc = -1;
    scyc = 0;
    res  = '0;
    stall_at_done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (bus.done_o) begin
        dcyc = c;
        res  = bus.result_o;
        stall_at_done = bus.stall_o;
        break;
      end
      if (bus.stall_o) scyc++;
      @(negedge clk);
      if (!hold) bus.start_i = 1'b0;
    end
  endtask

  task automatic finish_op();
    bus.advance_i = 1'b1;
    bus.start_i   = 1'b0;
    @(negedge clk);
    bus.advance_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.done_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset: done=%b stall=%b result=%h expected 0/0/00000000",
               bus.done_o, bus.stall_o, bus.result_o);
    end
  endtask

  task automatic test_mul_timing();
    int d, s;
    logic [31:0] r;
    logic sd;
    run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0, d, s, r, sd);
    checks++;
    if (d !== 34) begin errors++; $display("FAIL mul_done_cycle: got %0d expected 34", d); end
    checks++;
    if (s !== 34) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected 34", s); end
    checks++;
    if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
    checks++;
    if (sd !== 1'b0) begin errors++; $display("FAIL mul_stall_in_done: got %b expected 0", sd); end
    finish_op();
    checks++;
    if (bus.done_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_idle_after_advance: done=%b stall=%b expected 0/0", bus.done_o, bus.stall_o);
    end
  endtask

  task automatic test_mul_high();
    int d, s;
    logic [31:0] r;
    logic sd;
    run_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'hFFFF_FFFE || d !== 34) begin
      errors++; $display("FAIL mulhu: got %h at %0d expected fffffffe at 34", r, d);
    end
    finish_op();
    run_op(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'h0000_0000 || d !== 34) begin
      errors++; $display("FAIL mulh: got %h at %0d expected 00000000 at 34", r, d);
    end
    finish_op();
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'hFFFF_FFFF || d !== 34) begin
      errors++; $display("FAIL mulhsu: got %h at %0d expected ffffffff at 34", r, d);
    end
    finish_op();
  endtask

  task automatic test_div();
    int d, s;
    logic [31:0] r;
    logic sd;
    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'hFFFF_FFFD || d !== 34) begin
      errors++; $display("FAIL div_neg: got %h at %0d expected fffffffd at 34", r, d);
    end
    finish_op();
    run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'hFFFF_FFFF || d !== 34) begin
      errors++; $display("FAIL rem_neg: got %h at %0d expected ffffffff at 34", r, d);
    end
    finish_op();
    run_op(F3_REMU, 32'd100, 32'd7, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'd2 || d !== 34) begin
      errors++; $display("FAIL remu: got %h at %0d expected 00000002 at 34", r, d);
    end
    finish_op();
  endtask

  task automatic test_shortcuts();
    int d, s;
    logic [31:0] r;
    logic sd;
    run_op(F3_DIVU, 32'd5, 32'd0, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'hFFFF_FFFF || d !== 1 || s !== 1) begin
      errors++; $display("FAIL divu_by_zero: got %h at %0d stall %0d expected ffffffff at 1 stall 1", r, d, s);
    end
    finish_op();
    run_op(F3_REM, 32'd5, 32'd0, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'd5 || d !== 1 || s !== 1) begin
      errors++; $display("FAIL rem_by_zero: got %h at %0d stall %0d expected 00000005 at 1 stall 1", r, d, s);
    end
    finish_op();
    run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'h8000_0000 || d !== 1 || s !== 1) begin
      errors++; $display("FAIL div_overflow: got %h at %0d stall %0d expected 80000000 at 1 stall 1", r, d, s);
    end
    finish_op();
    run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'h0 || d !== 1) begin
      errors++; $display("FAIL rem_overflow: got %h at %0d expected 00000000 at 1", r, d);
    end
    finish_op();
  endtask

  task automatic test_flush();
    int d, s;
    int early_done;
    logic [31:0] r;
    logic sd;
    early_done = 0;
    bus.start_i    = 1'b1;
    bus.op_i       = F3_DIV;
    bus.rs1_data_i = 32'hFFFF_FFF9;
    bus.rs2_data_i = 32'd2;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.done_o) early_done++;
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    checks++;
    if (early_done != 0 || bus.done_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort: early_done=%0d done=%b stall=%b expected 0/0/0",
               early_done, bus.done_o, bus.stall_o);
    end
    @(negedge clk);
    run_op(F3_DIVU, 32'd100, 32'd7, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'd14 || d !== 34) begin
      errors++; $display("FAIL after_flush_divu: got %h at %0d expected 0000000e at 34", r, d);
    end
    finish_op();
  endtask

  task automatic test_hold_done();
    int d, s;
    int bad;
    logic [31:0] r;
    logic sd;
    bad = 0;
    run_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, d, s, r, sd);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus.done_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.result_o !== 32'hFFFF_FFFE) bad++;
    end
    checks++;
    if (bad != 0 || d !== 34) begin
      errors++; $display("FAIL hold_done: %0d bad cycles, done at %0d, expected 0 bad at 34", bad, d);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    bus.start_i    = 1'b1;
    bus.op_i       = F3_MUL;
    bus.rs1_data_i = 32'd7;
    bus.rs2_data_i = 32'hFFFF_FFFD;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.done_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_calc: done=%b stall=%b result=%h expected 0/0/00000000",
               bus.done_o, bus.stall_o, bus.result_o);
    end
  endtask

  task automatic test_back_to_back();
    int d, s;
    logic [31:0] r;
    logic sd;
    run_op(F3_MUL, 32'd3, 32'd5, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'd15 || d !== 34) begin
      errors++; $display("FAIL b2b_first: got %h at %0d expected 0000000f at 34", r, d);
    end
    finish_op();
    run_op(F3_MULHU, 32'h8000_0000, 32'd4, 1'b0, d, s, r, sd);
    checks++;
    if (r !== 32'd2 || d !== 34) begin
      errors++; $display("FAIL b2b_second: got %h at %0d expected 00000002 at 34", r, d);
    end
    finish_op();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.op_i       = 3'b000;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
    bus.flush_i    = 1'b0;
    bus.advance_i  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_div();
    test_shortcuts();
    test_flush();
    test_hold_done();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
